// File: rtl/muldiv_seq_if.sv
// Request/response bundle between decode/execute and the multiply/divide sequencer.
// Master drives the request and flush; slave returns busy, done and result.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: fixed-latency registered multiply, 1-bit/cycle restoring divide.
// Latency: MUL_CYCLES for multiplies, 34 for divides, 1 for divide special cases (and cache hits).
// Backpressure: busy stalls the pipeline; start while busy is dropped. MULDIV_REMCACHE_EN enables the result cache.
module muldiv_seq #(
    parameter int MUL_CYCLES = 2,
    parameter int XLEN       = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    state_t          state;
    logic [XLEN-1:0] quo_r;   // dividend shifting into quotient, or multiplicand
    logic [XLEN-1:0] dvs_r;   // divisor, or multiplier
    logic [XLEN-1:0] rem_r;
    logic [4:0]      cnt;
    logic [2:0]      op_r;
    logic            q_neg;
    logic            r_neg;

    function automatic logic [XLEN-1:0] mul_res(input logic [2:0] f3,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
        logic            sx, sy;
        logic [2*XLEN-1:0] xe, ye, p;
        sx = (f3[1:0] != 2'b11) & x[XLEN-1];
        sy = ~f3[1] & y[XLEN-1];
        xe = {{XLEN{sx}}, x};
        ye = {{XLEN{sy}}, y};
        p  = xe * ye;
        return (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Request decode for divide-class operations.
    logic            sgn, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0] abs_a, abs_b, spec_res;

    always_comb begin
        sgn      = ~bus.op[0];
        a_neg    = sgn & bus.a[XLEN-1];
        b_neg    = sgn & bus.b[XLEN-1];
        abs_a    = a_neg ? -bus.a : bus.a;
        abs_b    = b_neg ? -bus.b : bus.b;
        b_zero   = (bus.b == '0);
        ovf      = sgn & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b);
        spec_res = '0;
        if (b_zero)
            spec_res = bus.op[1] ? bus.a : '1;
        else
            spec_res = bus.op[1] ? '0 : bus.a;
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [XLEN:0]   trial;
    logic            step_ok;
    logic [XLEN-1:0] rem_nxt, quo_nxt, q_fin, r_fin;

    always_comb begin
        trial   = {rem_r, quo_r[XLEN-1]} - {1'b0, dvs_r};
        step_ok = ~trial[XLEN];
        rem_nxt = step_ok ? trial[XLEN-1:0] : {rem_r[XLEN-2:0], quo_r[XLEN-1]};
        quo_nxt = {quo_r[XLEN-2:0], step_ok};
        q_fin   = q_neg ? -quo_r : quo_r;
        r_fin   = r_neg ? -rem_r : rem_r;
    end

`ifdef MULDIV_REMCACHE_EN
    logic            c_vld;
    logic            c_sgn;
    logic [XLEN-1:0] c_a, c_b, c_quo, c_rem;
    logic            c_hit;

    assign c_hit = c_vld & (c_a == bus.a) & (c_b == bus.b) & (c_sgn == sgn);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
            rem_r  <= '0;
            cnt    <= '0;
            op_r   <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
`ifdef MULDIV_REMCACHE_EN
            c_vld  <= 1'b0;
            c_sgn  <= 1'b0;
            c_a    <= '0;
            c_b    <= '0;
            c_quo  <= '0;
            c_rem  <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (bus.flush) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
`ifdef MULDIV_REMCACHE_EN
                c_vld    <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            op_r <= bus.op;
                            if (!bus.op[2]) begin
                                if (MUL_CYCLES == 1) begin
                                    bus.result <= mul_res(bus.op, bus.a, bus.b);
                                    bus.done   <= 1'b1;
`ifdef MULDIV_REMCACHE_EN
                                    c_vld      <= 1'b0;
`endif
                                end else begin
                                    quo_r    <= bus.a;
                                    dvs_r    <= bus.b;
                                    cnt      <= 5'(MUL_CYCLES - 2);
                                    state    <= MUL;
                                    bus.busy <= 1'b1;
                                end
                            end else if (b_zero || ovf) begin
                                bus.result <= spec_res;
                                bus.done   <= 1'b1;
                            end
`ifdef MULDIV_REMCACHE_EN
                            else if (c_hit) begin
                                bus.result <= bus.op[1] ? c_rem : c_quo;
                                bus.done   <= 1'b1;
                            end
`endif
                            else begin
                                quo_r    <= abs_a;
                                dvs_r    <= abs_b;
                                rem_r    <= '0;
                                q_neg    <= a_neg ^ b_neg;
                                r_neg    <= a_neg;
                                cnt      <= 5'(XLEN - 1);
                                state    <= DIV;
                                bus.busy <= 1'b1;
`ifdef MULDIV_REMCACHE_EN
                                // Key is captured now; entry only goes valid at FIXUP.
                                c_vld    <= 1'b0;
                                c_a      <= bus.a;
                                c_b      <= bus.b;
                                c_sgn    <= sgn;
`endif
                            end
                        end
                    end
                    MUL: begin
                        if (cnt == '0) begin
                            bus.result <= mul_res(op_r, quo_r, dvs_r);
                            bus.done   <= 1'b1;
                            bus.busy   <= 1'b0;
                            state      <= IDLE;
`ifdef MULDIV_REMCACHE_EN
                            c_vld      <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    DIV: begin
                        quo_r <= quo_nxt;
                        rem_r <= rem_nxt;
                        if (cnt == '0)
                            state <= FIXUP;
                        else
                            cnt <= cnt - 5'd1;
                    end
                    FIXUP: begin
                        bus.result <= op_r[1] ? r_fin : q_fin;
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
`ifdef MULDIV_REMCACHE_EN
                        c_vld      <= 1'b1;
                        c_quo      <= q_fin;
                        c_rem      <= r_fin;
`endif
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboarded bench for muldiv_seq: driver pushes expected result and due cycle,
// a negedge monitor pops and compares whenever done pulses.
module tb_muldiv_seq;
    localparam int MC = 2;
`ifdef MULDIV_REMCACHE_EN
    localparam int CL = 1;
`else
    localparam int CL = 34;
`endif

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
                           OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.MUL_CYCLES(MC), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: done high at cycle %0d, no request outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.result !== mon_e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h expected %h", mon_e.name, bus.result, mon_e.res);
                end
                checks++;
                if (cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL %s latency: done at cycle %0d expected %0d", mon_e.name, cyc, mon_e.due);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle so the next
    // call issues back-to-back. poke >= 0 fires an extra start mid-operation.
    task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                         input int poke);
        exp_t e;
        logic busy_ok, got;
        e.res  = exp_res;
        e.due  = cyc + lat;
        e.name = nm;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        busy_ok   = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (i == poke) begin
                bus.start = 1'b1;
                bus.op    = OP_MUL;
                bus.a     = 32'd3;
                bus.b     = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within 60 cycles", nm);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy: busy dropped to 0 before done", nm);
        end
    endtask

    task automatic expect_bit(input string nm, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp_v);
        end
    endtask

    task automatic expect_word(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        expect_bit("reset_busy", bus.busy, 1'b0);
        expect_bit("reset_done", bus.done, 1'b0);
        expect_word("reset_result", bus.result, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        issue("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 34, 5);
        issue("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2, CL, -1);
        issue("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, -1);
        issue("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, CL, -1);
        issue("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, -1);
        issue("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, -1);
        issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, -1);
        issue("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, -1);
        issue("mulh_m1", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, MC, -1);
        issue("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MC, -1);
        issue("mul_m1", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, MC, -1);
        issue("mulhsu_m1", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, -1);
        issue("rem_after_mul", OP_REM, 32'd100, 32'd7, 32'd2, 34, -1);
        issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, -1);
        issue("rem_7_m2", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, CL, -1);
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, -1);

        // Flush ten cycles into a long divide.
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        expect_bit("flush_busy_before", bus.busy, 1'b1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        expect_bit("flush_busy_after", bus.busy, 1'b0);
        expect_bit("flush_no_done", bus.done, 1'b0);
        expect_word("flush_result_held", bus.result, 32'd14);
        repeat (3) @(negedge clk);
        issue("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, -1);

        // Flush together with start in IDLE drops the request.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd5;
        bus.b     = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        expect_bit("flush_start_done", bus.done, 1'b0);
        expect_bit("flush_start_busy", bus.busy, 1'b0);
        expect_word("flush_start_result", bus.result, 32'd3);

        // Reset in the middle of a divide.
        issue("divu_9_3_b", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, -1);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        expect_bit("midop_rst_busy", bus.busy, 1'b0);
        expect_bit("midop_rst_done", bus.done, 1'b0);
        expect_word("midop_rst_result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue("divu_9_3_post_rst", OP_DIVU, 32'd9, 32'd3, 32'd3, 34, -1);

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected results never seen, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations.
- Accepts one request at a time from decode and runs a registered multiply of fixed latency, or a 1-bit/cycle restoring divide.
- Drives busy so the pipeline stalls, and returns the result with a single-cycle done pulse.
- Sits beside the single-cycle ALU in execute; the ALU keeps the base integer ops.

Parameters:
- MUL_CYCLES, 2, cycles from start to done for MUL/MULH/MULHSU/MULHU; legal range 1..4.
- XLEN, 32, operand width; only 32 supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request valid; sampled only when not busy
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand
- b  input  32  rs2 operand
- flush  input  1  synchronous abort of the in-flight operation
- busy  output  1  operation in flight; pipeline stalls
- done  output  1  one-cycle pulse; result valid
- result  output  32  result; held until next accepted start

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, result=0, iteration counter=0, internal operand/quotient/remainder registers=0.
- States: IDLE, MUL, DIV, FIXUP.
  - busy = 1 in MUL, DIV, FIXUP.
  - done is registered; it pulses high for exactly the first cycle back in IDLE after completion.
- Accept: start && state==IDLE, sampled at edge E0. Start while busy is ignored; requests are not queued.
  - Start in the cycle done is high is legal, giving back-to-back operation.
- MUL path: E0 latches operands and enters MUL.
  - Product: 64-bit.
    - MUL and MULH: signed x signed.
    - MULHSU: signed a x unsigned b.
    - MULHU: unsigned x unsigned.
  - MUL returns bits[31:0]; the other three return bits[63:32].
  - done is visible MUL_CYCLES cycles after the start cycle.
- DIV path, normal case: E0 latches |a| and |b| (unsigned ops take raw values), records quotient sign and remainder sign (sign of a), sets counter=31, and enters DIV.
  - Each edge performs one restoring step, MSB first.
  - After 32 steps, enter FIXUP.
  - FIXUP negates the quotient and/or remainder as needed.
  - done is visible 34 cycles after the start cycle.
- Divide special cases skip DIV/FIXUP; done is visible 1 cycle after start.
  - b==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF, DIV/REM only): DIV returns 0x80000000; REM returns 0.
- Signed rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
- flush: at the next edge state goes to IDLE, busy goes to 0, and no done is issued. result keeps its prior value.
  - flush together with start in IDLE: flush wins; the request is dropped.
- rst mid-operation: immediate return to reset values; no done.
- Inputs a, b, op need only be stable in the start cycle.

Optional Feature:
- Macro: MULDIV_REMCACHE_EN.
- When defined, after a normal-path DIV/DIVU/REM/REMU completes, the block stores a, b, signedness, and both the final quotient and final remainder, and marks them valid.
- A later divide-class request with identical a, b and signedness returns the cached value with done 1 cycle after start.
  - Example: DIV followed by REM of the same operands.
- The cache is invalidated by rst, flush, or any MUL-class completion.
- When undefined: no cache registers; every divide takes the full latency.

Test Plan:
- DIV a=100, b=7 -> done 34 cycles after start, result=14; busy high throughout; second start mid-op ignored.
- REM a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFF (-1); DIV same operands -> 0xFFFFFFFD (-3).
- DIVU a=5, b=0 -> result=0xFFFFFFFF in 1 cycle; REMU a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- MULH a=b=0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; MUL same -> 0x00000001; each done at MUL_CYCLES; back-to-back start on done cycle accepted.
- DIV 1000/3 with flush asserted 10 cycles after start -> busy 0 next cycle, no done, result unchanged; new DIVU 9/3 then completes with result=3.
- With MULDIV_REMCACHE_EN: DIV 100/7 (34 cycles, result 14), then REM 100/7 -> result 2 in 1 cycle; after a MUL, REM 100/7 takes 34 cycles.
